// File: rtl/nrisc_pkg.sv
// Shared nRisc definitions: opcodes, fetch-sequencer state encoding and default widths.
package nrisc_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 8;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_MOVE = 3'd1;
    localparam logic [2:0] OP_SLT  = 3'd2;
    localparam logic [2:0] OP_BEQ  = 3'd3;
    localparam logic [2:0] OP_JMP  = 3'd4;
    localparam logic [2:0] OP_SW   = 3'd5;
    localparam logic [2:0] OP_LW   = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: jump, taken branch, or sequential, all modulo 2^ADDR_W.
module pc_next_calc #(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [4:0]        imm,
    input  logic              jump,
    input  logic              branch,
    input  logic              zero,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] offset;

    assign pc_seq = pc + ADDR_W'(1);
    assign offset = {{(ADDR_W-5){imm[4]}}, imm};

    // Explicit == 1'b1 tests so that x/z on a control line reads as not asserted.
    always_comb begin
        next_pc = pc_seq;
        if (jump == 1'b1) begin
            next_pc = {pc[ADDR_W-1:5], imm};
        end else if (branch == 1'b1 && zero == 1'b1) begin
            next_pc = pc_seq + offset;
        end
    end

endmodule

// File: rtl/pc_fetch_seq.sv
// nRisc instruction fetch / PC sequencer: fetches over req/ack, holds IR, and steps the PC
// from the control unit's Branch/Jump/EscPc decisions.
module pc_fetch_seq
    import nrisc_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [2:0]         OPcode,
    output logic [4:0]         imm,
    input  logic               Branch,
    input  logic               Jump,
    input  logic               EscPc,
    input  logic               zero,
    input  logic               exec_done,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted,
    output state_t             dbg_state
);

    // Handshake: imem_req is held high for every FETCH cycle with imem_addr = pc; a fetch
    // completes on the first cycle imem_ack is high while in FETCH (same cycle allowed).
    // imem_ack in any other state is ignored.

    localparam logic [INSTR_W-1:0] IR_RESET = {3'b111, {(INSTR_W-3){1'b0}}};

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  ir_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   next_pc;
    logic                ir_load;
    logic                pc_load;

    pc_next_calc #(.ADDR_W(ADDR_W)) u_next (
        .pc      (pc_q),
        .imm     (ir_q[4:0]),
        .jump    (Jump),
        .branch  (Branch),
        .zero    (zero),
        .next_pc (next_pc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ir_q    <= IR_RESET;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (ir_load) ir_q <= imem_data;
            if (pc_load) pc_q <= next_pc;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_load = 1'b0;
        pc_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start == 1'b1) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack == 1'b1) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (exec_done == 1'b1) begin
                    // Anything but a clean 1 on EscPc stops the core with pc untouched.
                    if (EscPc == 1'b1) begin
                        pc_load = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign OPcode    = ir_q[INSTR_W-1 -: 3];
    assign imm       = ir_q[4:0];
    assign pc        = pc_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC);
    assign halted    = (state_q == ST_HALT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Bench for pc_fetch_seq: directed vector table, hand-written stall/wrap/reset sequences,
// and random instruction streams checked against an arithmetic next-PC model.
module tb_pc_fetch_seq;
    import nrisc_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic [2:0] OPcode;
    logic [4:0] imm;
    logic       Branch = 1'b0;
    logic       Jump = 1'b0;
    logic       EscPc = 1'b1;
    logic       zero = 1'b0;
    logic       exec_done = 1'b0;
    logic [7:0] pc;
    logic       busy;
    logic       halted;
    state_t     dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [7:0] tb_pc = 8'h00;

    pc_fetch_seq dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .OPcode    (OPcode),
        .imm       (imm),
        .Branch    (Branch),
        .Jump      (Jump),
        .EscPc     (EscPc),
        .zero      (zero),
        .exec_done (exec_done),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference next-PC rule in plain integer arithmetic.
    function automatic logic [7:0] model_next(input int cur, input logic [7:0] instr,
                                              input bit br, input bit jp, input bit z);
        int off;
        int v;
        off = int'(instr[4:0]);
        if (off >= 16) off = off - 32;
        if (jp) v = (cur / 32) * 32 + int'(instr[4:0]);
        else if (br && z) v = cur + 1 + off;
        else v = cur + 1;
        v = ((v % 256) + 256) % 256;
        return v[7:0];
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tb_pc = 8'h00;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_req", imem_req, 1);
        check("start_addr", imem_addr, tb_pc);
    endtask

    // One full instruction: fetch (with ack delay), decode, exec (with exec_done delay).
    task automatic run_instr(input logic [7:0] instr, input bit br, input bit jp, input bit esc,
                             input bit z, input int ack_dly, input int done_dly,
                             input logic [7:0] exp_pc, input bit exp_halt);
        int guard = 0;
        while (imem_req !== 1'b1 && guard < 64) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 64) begin
            check("req_timeout", imem_req, 1);
            return;
        end
        check("fetch_addr", imem_addr, tb_pc);
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clock);
            check("stall_req", imem_req, 1);
            check("stall_addr", imem_addr, tb_pc);
        end
        imem_data = instr;
        imem_ack  = 1'b1;
        @(negedge clock);
        imem_ack  = 1'b0;
        imem_data = 8'($urandom);
        check("decode_opcode", OPcode, instr[7:5]);
        check("decode_imm", imm, instr[4:0]);
        check("decode_noreq", imem_req, 0);
        check("decode_busy", busy, 1);
        @(negedge clock);
        Branch = br;
        Jump   = jp;
        EscPc  = esc;
        zero   = z;
        exec_done = 1'b0;
        for (int i = 0; i < done_dly; i++) begin
            @(negedge clock);
            check("exec_opcode_held", OPcode, instr[7:5]);
            check("exec_pc_held", pc, tb_pc);
        end
        exec_done = 1'b1;
        @(negedge clock);
        exec_done = 1'b0;
        Branch = 1'b0;
        Jump   = 1'b0;
        EscPc  = 1'b1;
        zero   = 1'b0;
        check("next_pc", pc, exp_pc);
        check("halted", halted, exp_halt);
        check("req_after", imem_req, !exp_halt);
        tb_pc = exp_pc;
    endtask

    typedef struct {
        logic [7:0] instr;
        bit         br;
        bit         jp;
        bit         esc;
        bit         z;
        int         ack_dly;
        int         done_dly;
        logic [7:0] exp_pc;
        bit         exp_halt;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int c0;
        vecs[0]  = '{8'h01, 0, 0, 1, 0, 0, 0, 8'h01, 0};
        vecs[1]  = '{8'h85, 0, 1, 1, 0, 0, 0, 8'h05, 0};
        vecs[2]  = '{8'h7E, 1, 0, 1, 1, 0, 0, 8'h04, 0};
        vecs[3]  = '{8'h01, 0, 0, 1, 0, 1, 0, 8'h05, 0};
        vecs[4]  = '{8'h7E, 1, 0, 1, 0, 0, 0, 8'h06, 0};
        vecs[5]  = '{8'h9F, 0, 1, 1, 0, 0, 1, 8'h1F, 0};
        vecs[6]  = '{8'h01, 0, 0, 1, 0, 0, 0, 8'h20, 0};
        vecs[7]  = '{8'h83, 0, 1, 1, 0, 0, 0, 8'h23, 0};
        vecs[8]  = '{8'h90, 1, 1, 1, 1, 0, 0, 8'h30, 0};
        vecs[9]  = '{8'h7E, 1, 0, 1, 1, 2, 1, 8'h2F, 0};
        vecs[10] = '{8'hE0, 0, 0, 0, 0, 0, 0, 8'h2F, 1};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_pc", pc, 8'h00);
        check("rst_req", imem_req, 0);
        check("rst_opcode", OPcode, 3'b111);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_state", dbg_state, ST_IDLE);
        imem_ack = 1'b1;
        @(negedge clock);
        imem_ack = 1'b0;
        check("idle_ack_ignored", busy, 0);

        pulse_start();
        c0 = cyc;
        foreach (vecs[i]) begin
            run_instr(vecs[i].instr, vecs[i].br, vecs[i].jp, vecs[i].esc, vecs[i].z,
                      vecs[i].ack_dly, vecs[i].done_dly, vecs[i].exp_pc, vecs[i].exp_halt);
            if (i == 0) check("three_cycle_cost", cyc - c0, 3);
        end

        for (int i = 0; i < 20; i++) begin
            start = (i % 3 == 0);
            @(negedge clock);
            check("halt_noreq", imem_req, 0);
            check("halt_sticky", halted, 1);
            check("halt_busy", busy, 0);
            check("halt_pc", pc, 8'h2F);
        end
        start = 1'b0;
        do_reset();
        check("halt_reset_pc", pc, 8'h00);
        check("halt_reset_state", dbg_state, ST_IDLE);
        check("halt_reset_halted", halted, 0);

        // Wrap both ways around 00/FF with fetch and exec stalls.
        pulse_start();
        run_instr(8'h7E, 1, 0, 1, 1, 0, 0, 8'hFF, 0);
        run_instr(8'h01, 0, 0, 1, 0, 4, 3, 8'h00, 0);
        run_instr(8'h7E, 1, 0, 1, 1, 0, 0, 8'hFF, 0);
        run_instr(8'h6F, 1, 0, 1, 1, 0, 0, 8'h0F, 0);

        do_reset();
        pulse_start();
        run_instr(8'h7E, 1, 0, 1, 1, 0, 0, 8'hFF, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midfetch_reset_req", imem_req, 0);
        check("midfetch_reset_pc", pc, 8'h00);
        imem_ack = 1'b1;
        imem_data = 8'h01;
        @(negedge clock);
        imem_ack = 1'b0;
        check("late_ack_req", imem_req, 0);
        check("late_ack_state", dbg_state, ST_IDLE);
        check("late_ack_opcode", OPcode, 3'b111);
        tb_pc = 8'h00;

        for (int run = 0; run < 3; run++) begin
            do_reset();
            pulse_start();
            for (int k = 0; k < 30; k++) begin
                logic [7:0] ins;
                bit br, jp, z, esc;
                logic [7:0] exp;
                ins = 8'($urandom);
                br  = 1'($urandom_range(0, 1));
                jp  = ($urandom_range(0, 3) == 0);
                z   = 1'($urandom_range(0, 1));
                esc = (k != 29);
                exp = esc ? model_next(int'(tb_pc), ins, br, jp, z) : tb_pc;
                run_instr(ins, br, jp, esc, z, $urandom_range(0, 3), $urandom_range(0, 2),
                          exp, !esc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
